// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: passes ALU/JAL results through and runs loads/stores
// on a req/ack data port with lane alignment, extension, misalignment check and timeout.
module mem_stage_lsu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            flush,
  input  logic            halt,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic            wb_valid,
  output logic            wb_rd_we,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] wb_instr,
  output logic            misalign_exc,
  output logic            bus_err
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [1:0]      a_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] instr_q;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [1:0]      a;
  logic            is_ls;
  logic            size_half;
  logic            size_word;
  logic            misal;
  logic            accept;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_c;
  logic [TO_W-1:0] cnt_nxt;

  // Decode of the instruction presented this cycle
  always_comb begin
    opcode    = instr_in[6:0];
    f3        = instr_in[14:12];
    a         = alu_in[1:0];
    is_ls     = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    size_half = (f3[1:0] == 2'b01);
    size_word = f3[1];
    misal     = (size_half & a[0]) | (size_word & (a != 2'b00));
    accept    = valid_in & ~flush & ~halt & (state == S_IDLE);
    cnt_nxt   = TO_W'(cnt + 1'b1);
    if (size_word) begin
      be_c    = 4'b1111;
      wdata_c = rs2_in;
    end else if (size_half) begin
      be_c    = 4'b0011 << a;
      wdata_c = XLEN'({2{rs2_in[15:0]}});
    end else begin
      be_c    = 4'b0001 << a;
      wdata_c = XLEN'({4{rs2_in[7:0]}});
    end
  end

  // Load lane extraction and extension from the access latched on entry to WAIT
  always_comb begin
    lane = dmem_rdata >> {a_q, 3'b000};
    case (f3_q)
      3'b000:  load_c = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  load_c = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  load_c = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  load_c = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: load_c = lane;
    endcase
  end

  // Held in reset so a reset during WAIT releases upstream immediately
  assign stall_out = ~rst & ((state == S_WAIT) | (accept & is_ls & ~misal));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      a_q          <= '0;
      f3_q         <= '0;
      instr_q      <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_rd_we     <= 1'b0;
      wb_data      <= '0;
      wb_instr     <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_rd_we     <= 1'b0;
      wb_data      <= '0;
      wb_instr     <= '0;
      misalign_exc <= 1'b0;
      bus_err      <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          case (opcode)
            OPC_LOAD, OPC_STORE: begin
              if (misal) begin
                misalign_exc <= 1'b1;
              end else begin
                state      <= S_WAIT;
                cnt        <= '0;
                a_q        <= a;
                f3_q       <= f3;
                instr_q    <= instr_in;
                dmem_req   <= 1'b1;
                dmem_we    <= (opcode == OPC_STORE);
                dmem_addr  <= {alu_in[XLEN-1:2], 2'b00};
                dmem_be    <= be_c;
                dmem_wdata <= wdata_c;
              end
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
              wb_valid <= 1'b1;
              wb_rd_we <= 1'b1;
              wb_data  <= alu_in;
              wb_instr <= instr_in;
            end
            OPC_JAL, OPC_JALR: begin
              wb_valid <= 1'b1;
              wb_rd_we <= 1'b1;
              wb_data  <= pc_in + XLEN'(4);
              wb_instr <= instr_in;
            end
            default: begin
              wb_valid <= 1'b1;
              wb_instr <= instr_in;
            end
          endcase
        end
      end else begin
        // An ack in the timeout cycle still retires normally
        if (dmem_ack || (cnt_nxt == TO_W'(TIMEOUT))) begin
          state      <= S_IDLE;
          cnt        <= '0;
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_addr  <= '0;
          dmem_be    <= '0;
          dmem_wdata <= '0;
          if (dmem_ack) begin
            wb_valid <= 1'b1;
            wb_instr <= instr_q;
            wb_rd_we <= ~dmem_we;
            wb_data  <= dmem_we ? '0 : load_c;
          end else begin
            bus_err <= 1'b1;
          end
        end else begin
          cnt <= cnt_nxt;
        end
      end
    end
  end

endmodule
